// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM byte-wide RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_IF_RD  = 3'd1,
        ARB_MEM_RD = 3'd2,
        ARB_MEM_WR = 3'd3,
        ARB_DONE   = 3'd4
    } arb_state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Byte count of a MEM request; the reserved encoding behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// load/store stage, splitting multi-byte requests into little-endian byte cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              if_stall_req,
    output logic              mem_stall_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    arb_state_e        state_r;
    logic [2:0]        cnt_r;
    logic [2:0]        nbytes_r;
    logic [31:0]       base_r;
    logic [31:0]       wdata_r;
    logic [31:0]       asm_r;
    logic [31:0]       data_r;
    logic              is_if_r;
    logic              if_done_r;
    logic              mem_done_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_wr_r;
    logic [7:0]        ram_dout_r;

    logic [2:0]        next_idx_s;
    logic              next_last_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic [7:0]        next_byte_s;
    logic [1:0]        cap_lane_s;
    logic [31:0]       asm_next_s;

    // Next byte address/data and read assembly; cnt_r counts cycles since accept.
    always_comb begin
        next_idx_s  = cnt_r + 3'd1;
        next_last_s = (next_idx_s >= nbytes_r);
        next_addr_s = ADDR_W'(base_r + {29'd0, next_idx_s});
        next_byte_s = wdata_r[{next_idx_s[1:0], 3'b000} +: 8];
        cap_lane_s  = cnt_r[1:0] - 2'd1;
        asm_next_s  = asm_r;
        if (cnt_r != 3'd0) begin
            asm_next_s[{cap_lane_s, 3'b000} +: 8] = ram_din;
        end else begin
            asm_next_s = asm_r;
        end
    end

    // Arbitration FSM with registered RAM strobes, done pulses and read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ARB_IDLE;
            cnt_r      <= 3'd0;
            nbytes_r   <= 3'd0;
            base_r     <= 32'd0;
            wdata_r    <= 32'd0;
            asm_r      <= 32'd0;
            data_r     <= 32'd0;
            is_if_r    <= 1'b0;
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            ram_addr_r <= '0;
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'd0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    cnt_r <= 3'd0;
                    asm_r <= 32'd0;
                    if (mem_req) begin
                        state_r    <= mem_we ? ARB_MEM_WR : ARB_MEM_RD;
                        is_if_r    <= 1'b0;
                        base_r     <= mem_addr;
                        wdata_r    <= mem_wdata;
                        nbytes_r   <= len_bytes(mem_len);
                        ram_addr_r <= ADDR_W'(mem_addr);
                        ram_wr_r   <= mem_we;
                        ram_dout_r <= mem_we ? mem_wdata[7:0] : 8'd0;
                    end else if (if_req && !if_flush) begin
                        state_r    <= ARB_IF_RD;
                        is_if_r    <= 1'b1;
                        base_r     <= if_addr;
                        wdata_r    <= 32'd0;
                        nbytes_r   <= 3'd4;
                        ram_addr_r <= ADDR_W'(if_addr);
                        ram_wr_r   <= 1'b0;
                        ram_dout_r <= 8'd0;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_IF_RD, ARB_MEM_RD: begin
                    if ((state_r == ARB_IF_RD) && if_flush) begin
                        // Branch taken: drop the fetch without a done pulse.
                        state_r    <= ARB_IDLE;
                        cnt_r      <= 3'd0;
                        ram_addr_r <= '0;
                    end else begin
                        asm_r      <= asm_next_s;
                        cnt_r      <= next_idx_s;
                        ram_addr_r <= next_last_s ? '0 : next_addr_s;
                        if (cnt_r == nbytes_r) begin
                            state_r    <= ARB_DONE;
                            data_r     <= asm_next_s;
                            if_done_r  <= is_if_r;
                            mem_done_r <= !is_if_r;
                        end else begin
                            state_r <= state_r;
                        end
                    end
                end
                ARB_MEM_WR: begin
                    cnt_r <= next_idx_s;
                    if (next_last_s) begin
                        state_r    <= ARB_DONE;
                        mem_done_r <= 1'b1;
                        data_r     <= 32'd0;
                        ram_addr_r <= '0;
                        ram_wr_r   <= 1'b0;
                        ram_dout_r <= 8'd0;
                    end else begin
                        ram_addr_r <= next_addr_s;
                        ram_wr_r   <= 1'b1;
                        ram_dout_r <= next_byte_s;
                    end
                end
                ARB_DONE: begin
                    state_r    <= ARB_IDLE;
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    data_r     <= 32'd0;
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // A late branch flush still cancels the fetch completion in its done cycle.
    assign if_done       = if_done_r & ~if_flush;
    assign if_data       = if_done ? data_r : 32'd0;
    assign mem_done      = mem_done_r;
    assign mem_rdata     = mem_done_r ? data_r : 32'd0;
    assign if_stall_req  = rst & if_req & ~if_done;
    assign mem_stall_req = rst & mem_req & ~mem_done_r;
    assign ram_addr      = ram_addr_r;
    assign ram_wr        = ram_wr_r;
    assign ram_dout      = ram_dout_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-addressed RAM model, a reference
// memory image and queues of expected done events and RAM writes.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata, ram_addr;
    logic        if_done, mem_done, if_stall_req, mem_stall_req, ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'd0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_if; logic [31:0] data; int unsigned cyc; } done_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int unsigned cyc; } wr_t;
    done_t exp_q[$];
    wr_t   wr_q[$];
    int vectors = 0;
    int miscompares = 0;

    // Memory image: preload (fixed at time 0) overlaid by bytes the DUT writes.
    logic [7:0] pre_m [0:65535];
    logic [7:0] wr_m  [0:65535];
    bit         wr_v  [0:65535];
    logic [7:0] ref_m [0:65535];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return wr_v[a[15:0]] ? wr_m[a[15:0]] : pre_m[a[15:0]];
    endfunction

    // RAM model: writes on the strobe, read data appears the cycle after the address.
    always @(posedge clk) begin
        if (ram_wr === 1'b1) begin
            wr_m[ram_addr[15:0]] <= ram_dout;
            wr_v[ram_addr[15:0]] <= 1'b1;
        end
        ram_din <= ram_rd(ram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse and every RAM write must match the next expectation.
    always @(negedge clk) begin
        if (mem_done === 1'b1 || if_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, if_done, mem_done}, 32'd0);
            end else begin
                done_t e;
                e = exp_q.pop_front();
                check("done_source", {31'd0, if_done}, {31'd0, e.is_if});
                check("done_data", if_done ? if_data : mem_rdata, e.data);
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (ram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", ram_addr, 32'hFFFF_FFFF ^ ram_addr);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("wr_addr", ram_addr, w.addr);
                check("wr_data", {24'd0, ram_dout}, {24'd0, w.data});
                check("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int unsigned n);
        logic [31:0] d = 32'd0;
        for (int k = 0; k < n; k++) d[8*k +: 8] = ref_m[16'(a + 32'(k))];
        return d;
    endfunction

    task automatic check_quiet(input string name);
        check({name, "_if_data"}, if_data, 32'd0);
        check({name, "_if_done"}, {31'd0, if_done}, 32'd0);
        check({name, "_mem_rdata"}, mem_rdata, 32'd0);
        check({name, "_mem_done"}, {31'd0, mem_done}, 32'd0);
        check({name, "_stalls"}, {30'd0, if_stall_req, mem_stall_req}, 32'd0);
        check({name, "_ram_addr"}, ram_addr, 32'd0);
        check({name, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
        check({name, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    endtask

    task automatic wait_done(input bit is_if, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if ((is_if ? if_done : mem_done) === 1'b1) got = 1'b1;
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Drive a MEM request at the current cycle and record what it must produce.
    task automatic issue_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                             input logic [31:0] wd, output int unsigned done_cyc);
        int unsigned t = cyc;
        int unsigned n = nbytes(len);
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
        if (we) begin
            for (int k = 0; k < n; k++) begin
                wr_q.push_back('{a + 32'(k), wd[8*k +: 8], t + 1 + k});
                ref_m[16'(a + 32'(k))] = wd[8*k +: 8];
            end
            done_cyc = t + n + 1;
            exp_q.push_back('{1'b0, 32'd0, done_cyc});
        end else begin
            done_cyc = t + n + 2;
            exp_q.push_back('{1'b0, ref_word(a, n), done_cyc});
        end
    endtask

    task automatic mem_txn(input bit we, input logic [1:0] len, input logic [31:0] a,
                           input logic [31:0] wd);
        int unsigned dc;
        repeat ($urandom_range(0, 2)) tick();
        issue_mem(we, len, a, wd, dc);
        wait_done(1'b0, "mem");
        tick();
        mem_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a);
        repeat ($urandom_range(0, 2)) tick();
        if_req = 1'b1; if_addr = a;
        exp_q.push_back('{1'b1, ref_word(a, 4), cyc + 6});
        wait_done(1'b1, "if");
        tick();
        if_req = 1'b0;
    endtask

    // Both requesters in the same cycle: MEM first, IF in the IDLE cycle after.
    task automatic both_txn(input bit we, input logic [1:0] len, input logic [31:0] ma,
                            input logic [31:0] wd, input logic [31:0] ia);
        int unsigned dc;
        repeat ($urandom_range(0, 2)) tick();
        if_req = 1'b1; if_addr = ia;
        issue_mem(we, len, ma, wd, dc);
        exp_q.push_back('{1'b1, ref_word(ia, 4), dc + 1 + 6});
        wait_done(1'b0, "both_mem");
        tick();
        mem_req = 1'b0;
        wait_done(1'b1, "both_if");
        tick();
        if_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned dc;
        for (int i = 0; i < 65536; i++) begin
            pre_m[i] = 8'(i) ^ 8'(i >> 8) ^ 8'hA5;
        end
        pre_m[16'h1000] = 8'h13; pre_m[16'h1001] = 8'h00;
        pre_m[16'h1002] = 8'h50; pre_m[16'h1003] = 8'h00;
        pre_m[16'h3000] = 8'h80;
        for (int i = 0; i < 65536; i++) ref_m[i] = pre_m[i];

        rst = 1'b0; if_flush = 1'b0; mem_we = 1'b0; mem_len = 2'd0;
        if_addr = 32'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
        if_req = 1'b1; mem_req = 1'b1;

        // Reset with both requests high.
        tick(); check_quiet("reset1");
        tick(); check_quiet("reset2");
        if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;
        tick(); tick();

        // Directed: fetch, halfword store across bytes, simultaneous LB + fetch.
        if_txn(32'h0000_1000);
        mem_txn(1'b1, 2'd1, 32'h0000_2001, 32'hAABB_CCDD);
        both_txn(1'b0, 2'd0, 32'h0000_3000, 32'd0, 32'h0000_1000);

        // Flush two cycles into the fetch; a new fetch is accepted right after.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        tick(); tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h0000_1004;
        exp_q.push_back('{1'b1, ref_word(32'h0000_1004, 4), cyc + 6});
        wait_done(1'b1, "refetch");
        tick();
        if_req = 1'b0;

        // Flush landing exactly in the fetch's done cycle suppresses if_done.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_1008;
        repeat (6) tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        repeat (3) tick();

        // Reset after the first byte of a word store: no further bytes, no done.
        wr_q.push_back('{32'h0000_4000, 8'h11, cyc + 1});
        ref_m[16'h4000] = 8'h11;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h0000_4000; mem_wdata = 32'h4433_2211;
        tick();
        rst = 1'b0;
        tick();
        mem_req = 1'b0;
        check_quiet("midreset");
        rst = 1'b1;
        repeat (4) tick();
        mem_txn(1'b0, 2'd2, 32'h0000_4000, 32'd0);

        // Wrap-around across the top of the address space.
        mem_txn(1'b1, 2'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
        if_txn(32'hFFFF_FFFE);

        // Randomized mix against the reference image.
        for (int i = 0; i < 40; i++) begin
            int unsigned sel;
            logic [31:0] ma, ia, wd;
            logic [1:0]  len;
            bit          we;
            sel = $urandom_range(0, 5);
            ma  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3))
                                              : (32'h0000_5000 + $urandom_range(0, 31));
            ia  = 32'h0000_5000 + $urandom_range(0, 31);
            wd  = $urandom;
            len = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            case (sel)
                0, 1:    if_txn(ia);
                2, 3, 4: mem_txn(we, len, ma, wd);
                default: both_txn(we, len, ma, wd, ia);
            endcase
        end

        repeat (10) tick();
        check("pending_done", 32'(exp_q.size()), 32'd0);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
